// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner: latches a packed BCD word once per frame and
// drives one digit per slot. Optional leading-zero blanking: BCD_DISPLAY_LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
  parameter int DIGITS         = 3,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DIGITS*4-1:0]   bcd_in,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [DIGITS*4-1:0] r_snap;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_dig;
  logic                r_frame_start;

  logic                w_last_cnt;
  logic                w_last_idx;
  logic                w_lit;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_onehot;
  logic                w_lz_blank;
  logic [6:0]          w_seg_act;
  logic [DIGITS-1:0]   w_dig_act;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign w_last_cnt = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_last_idx = (r_idx == IW'(DIGITS - 1));
  // The first BLANK_CYCLES of each slot keep every digit dark to avoid ghosting.
  assign w_lit      = enable && (r_cnt >= CW'(BLANK_CYCLES));

  always_comb begin
    w_nib    = 4'd0;
    w_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib       = r_snap[k*4 +: 4];
        w_onehot[k] = 1'b1;
      end
    end
  end

`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; a digit is blanked while it and everything above it is zero.
  always_comb begin : lz_scan
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_lz_blank   = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      v_zero_above = v_zero_above && (r_snap[k*4 +: 4] == 4'd0);
      if (r_idx == IW'(k)) w_lz_blank = v_zero_above;
    end
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_seg_act = (w_lit && !w_lz_blank) ? decode(w_nib) : 7'h00;
  assign w_dig_act = w_lit ? w_onehot : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_snap        <= '0;
      r_seg         <= SEG_OFF;
      r_dig         <= DIG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      if (!enable) begin
        r_cnt  <= '0;
        r_idx  <= '0;
        r_snap <= bcd_in;
      end else begin
        r_cnt <= w_last_cnt ? '0 : r_cnt + CW'(1);
        if (w_last_cnt) begin
          r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
          if (w_last_idx) r_snap <= bcd_in;
        end
      end
      r_seg         <= w_seg_act ^ SEG_OFF;
      r_dig         <= w_dig_act ^ DIG_OFF;
      r_frame_start <= enable && (r_cnt == '0) && (r_idx == '0);
    end
  end

  assign seg         = r_seg;
  assign dig         = r_dig;
  assign frame_start = r_frame_start;

endmodule
